// File: rtl/med_lcd_if.sv
// Display-side bundle between the medication scheduler and the HD44780 driver.
// master = driver (owns the LCD pins), slave = scheduler/LCD side.
interface med_lcd_if;
  logic [7:0] disp_data;
  logic       disp_alarm;
  logic [3:0] lcd_db;
  logic       lcd_rs;
  logic       lcd_e;
  logic       busy;
  logic       init_done;

  modport master (
    input  disp_data, disp_alarm,
    output lcd_db, lcd_rs, lcd_e, busy, init_done
  );

  modport slave (
    output disp_data, disp_alarm,
    input  lcd_db, lcd_rs, lcd_e, busy, init_done
  );
endinterface

// File: rtl/med_lcd_driver.sv
// HD44780 4-bit driver: power-up init, then rewrites the "HH A" line-1 frame
// whenever the scheduler's display byte or alarm flag changes.
module med_lcd_driver #(
  parameter int E_CYCLES     = 5,
  parameter int CMD_WAIT     = 500,
  parameter int CLEAR_WAIT   = 20000,
  parameter int POWERUP_WAIT = 200000
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     ena,
  med_lcd_if.master bus
);

  typedef enum logic [1:0] {ST_PWRUP, ST_INIT, ST_IDLE, ST_FRAME} state_e;
  typedef enum logic [1:0] {PH_SETUP, PH_HIGH, PH_LOW, PH_WAIT} phase_e;

  localparam logic [19:0] E_LAST     = 20'(E_CYCLES - 1);
  localparam logic [19:0] CMD_LAST   = 20'(CMD_WAIT - 1);
  localparam logic [19:0] CLEAR_LAST = 20'(CLEAR_WAIT - 1);
  localparam logic [19:0] PWR_LAST   = 20'(POWERUP_WAIT - 1);
  localparam logic [2:0]  INIT_LAST  = 3'd7;
  localparam logic [2:0]  FRAME_LAST = 3'd4;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Entry is {rs, byte}. Init steps 0..3 are single high nibbles (8-bit mode wake-up).
  function automatic logic [8:0] seq_entry(input state_e st, input logic [2:0] step,
                                           input logic [8:0] snap);
    logic [8:0] e;
    e = 9'h120;
    if (st == ST_INIT) begin
      case (step)
        3'd0, 3'd1, 3'd2: e = 9'h030;
        3'd3:             e = 9'h020;
        3'd4:             e = 9'h028;
        3'd5:             e = 9'h00C;
        3'd6:             e = 9'h001;
        default:          e = 9'h006;
      endcase
    end else begin
      case (step)
        3'd0:    e = 9'h080;
        3'd1:    e = {1'b1, hex_char(snap[7:4])};
        3'd2:    e = {1'b1, hex_char(snap[3:0])};
        3'd3:    e = 9'h120;
        default: e = snap[8] ? 9'h141 : 9'h120;
      endcase
    end
    return e;
  endfunction

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  logic [19:0] cnt_q, cnt_d;
  logic [2:0]  step_q, step_d;
  logic        nib_lo_q, nib_lo_d;
  logic [8:0]  snap_q, snap_d;
  logic [3:0]  lcd_db_q, lcd_db_d;
  logic        lcd_rs_q, lcd_rs_d;
  logic        lcd_e_q, lcd_e_d;
  logic        busy_q, busy_d;
  logic        init_done_q, init_done_d;

  logic [8:0]  cur_entry, nxt_entry;
  logic [19:0] wait_last;
  logic        single_nib, last_step, load;

  always_comb begin
    cur_entry  = seq_entry(state_q, step_q, snap_q);
    single_nib = (state_q == ST_INIT) && (step_q < 3'd4);
    last_step  = (state_q == ST_INIT) ? (step_q == INIT_LAST) : (step_q == FRAME_LAST);
    wait_last  = (cur_entry == 9'h001) ? CLEAR_LAST : CMD_LAST;

    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    nib_lo_d    = nib_lo_q;
    snap_d      = snap_q;
    lcd_db_d    = lcd_db_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_e_d     = lcd_e_q;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    load        = 1'b0;

    if (ena) begin
      case (state_q)
        ST_PWRUP: begin
          if (cnt_q == PWR_LAST) begin
            cnt_d    = '0;
            state_d  = ST_INIT;
            phase_d  = PH_SETUP;
            step_d   = '0;
            nib_lo_d = 1'b0;
            load     = 1'b1;
          end else begin
            cnt_d = cnt_q + 20'd1;
          end
        end
        ST_IDLE: begin
          if ({bus.disp_alarm, bus.disp_data} != snap_q) begin
            snap_d   = {bus.disp_alarm, bus.disp_data};
            state_d  = ST_FRAME;
            phase_d  = PH_SETUP;
            step_d   = '0;
            nib_lo_d = 1'b0;
            busy_d   = 1'b1;
            load     = 1'b1;
          end
        end
        default: begin
          case (phase_q)
            PH_SETUP: begin
              phase_d = PH_HIGH;
              lcd_e_d = 1'b1;
              cnt_d   = '0;
            end
            PH_HIGH: begin
              if (cnt_q == E_LAST) begin
                phase_d = PH_LOW;
                lcd_e_d = 1'b0;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 20'd1;
              end
            end
            PH_LOW: begin
              if (cnt_q == E_LAST) begin
                cnt_d = '0;
                if (single_nib || nib_lo_q) begin
                  phase_d = PH_WAIT;
                end else begin
                  nib_lo_d = 1'b1;
                  phase_d  = PH_SETUP;
                  load     = 1'b1;
                end
              end else begin
                cnt_d = cnt_q + 20'd1;
              end
            end
            default: begin
              if (cnt_q == wait_last) begin
                cnt_d = '0;
                if (last_step && state_q == ST_FRAME) begin
                  state_d = ST_IDLE;
                  phase_d = PH_SETUP;
                  busy_d  = 1'b0;
                end else if (last_step) begin
                  // Forced refresh: capture current inputs even if they match the snapshot.
                  state_d     = ST_FRAME;
                  init_done_d = 1'b1;
                  snap_d      = {bus.disp_alarm, bus.disp_data};
                  step_d      = '0;
                  nib_lo_d    = 1'b0;
                  phase_d     = PH_SETUP;
                  load        = 1'b1;
                end else begin
                  step_d   = step_q + 3'd1;
                  nib_lo_d = 1'b0;
                  phase_d  = PH_SETUP;
                  load     = 1'b1;
                end
              end else begin
                cnt_d = cnt_q + 20'd1;
              end
            end
          endcase
        end
      endcase
    end

    // Nibble and rs are presented on entry to SETUP and then held through HIGH/LOW.
    nxt_entry = seq_entry(state_d, step_d, snap_d);
    if (load) begin
      lcd_rs_d = nxt_entry[8];
      lcd_db_d = nib_lo_d ? nxt_entry[3:0] : nxt_entry[7:4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PWRUP;
      phase_q     <= PH_SETUP;
      cnt_q       <= '0;
      step_q      <= '0;
      nib_lo_q    <= 1'b0;
      snap_q      <= '0;
      lcd_db_q    <= '0;
      lcd_rs_q    <= 1'b0;
      lcd_e_q     <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      nib_lo_q    <= nib_lo_d;
      snap_q      <= snap_d;
      lcd_db_q    <= lcd_db_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_e_q     <= lcd_e_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.lcd_db    = lcd_db_q;
  assign bus.lcd_rs    = lcd_rs_q;
  assign bus.lcd_e     = lcd_e_q;
  assign bus.busy      = busy_q;
  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_med_lcd_driver.sv
// Bench for med_lcd_driver: decodes the LCD bus into nibbles/characters and
// compares against sequences built from the display protocol rules.
module tb_med_lcd_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  med_lcd_if bus();

  med_lcd_driver #(
    .E_CYCLES(2), .CMD_WAIT(10), .CLEAR_WAIT(40), .POWERUP_WAIT(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [4:0] nib_cap[$];
  int ehigh_q[$];
  int frame_len_q[$];
  int low_len_q[$];
  int rel_cyc = 0, init_cyc = 0, first_rise = -1, busy_rise = 0, busy_fall = 0, hi_cnt = 0;
  logic e_prev = 1'b0, b_prev = 1'b1, id_prev = 1'b0;
  logic [4:0] rise_val = '0;
  logic [7:0] dd [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 10) return 8'h30 + 8'(n);
    return 8'h41 + 8'(n - 4'd10);
  endfunction

  function automatic logic [4:0] pop_nib();
    if (nib_cap.size() == 0) return 5'h1F;
    return nib_cap.pop_front();
  endfunction

  // Bus monitor sampled 2 time units after each rising edge.
  initial forever begin
    @(posedge clk);
    #2;
    if (!rst_n) begin
      e_prev = 1'b0; b_prev = 1'b1; id_prev = 1'b0; first_rise = -1;
    end else begin
      if (bus.lcd_e && !e_prev) begin
        nib_cap.push_back({bus.lcd_rs, bus.lcd_db});
        rise_val = {bus.lcd_rs, bus.lcd_db};
        hi_cnt = 1;
        if (first_rise < 0) first_rise = cyc - rel_cyc;
      end else if (bus.lcd_e) begin
        hi_cnt++;
      end else if (e_prev) begin
        ehigh_q.push_back(hi_cnt);
        chk("nibble_stable", 32'({bus.lcd_rs, bus.lcd_db}), 32'(rise_val));
      end
      if (bus.init_done && !id_prev) begin
        init_cyc = cyc;
        busy_rise = cyc;
      end
      if (!bus.busy && b_prev) begin
        frame_len_q.push_back(cyc - busy_rise);
        busy_fall = cyc;
      end else if (bus.busy && !b_prev) begin
        low_len_q.push_back(cyc - busy_fall);
        busy_rise = cyc;
      end
      e_prev = bus.lcd_e; b_prev = bus.busy; id_prev = bus.init_done;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_db"}, 32'(bus.lcd_db), 0);
    chk({tag, "_rs"}, 32'(bus.lcd_rs), 0);
    chk({tag, "_e"}, 32'(bus.lcd_e), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 1);
    chk({tag, "_init_done"}, 32'(bus.init_done), 0);
  endtask

  task automatic wait_idle(input int lim, input string tag);
    int n = 0;
    @(negedge clk);
    while (bus.busy !== 1'b0 && n < lim) begin @(negedge clk); n++; end
    chk(tag, 32'(bus.busy), 0);
  endtask

  task automatic wait_init(input int lim);
    int n = 0;
    while (bus.init_done !== 1'b1 && n < lim) begin @(negedge clk); n++; end
    chk("init_done_seen", 32'(bus.init_done), 1);
  endtask

  task automatic check_init();
    int seq [12] = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 1, 0, 6};
    for (int i = 0; i < 12; i++) chk($sformatf("init_nib%0d", i), 32'(pop_nib()), 32'(seq[i]));
  endtask

  task automatic check_frame(input logic [7:0] d, input logic a, input string tag);
    logic [8:0] eb [5];
    logic [4:0] got [10];
    logic [4:0] exp;
    logic [7:0] b;
    int addr = 0;
    eb[0] = 9'h080;
    eb[1] = {1'b1, hexc(d[7:4])};
    eb[2] = {1'b1, hexc(d[3:0])};
    eb[3] = {1'b1, 8'h20};
    eb[4] = {1'b1, a ? 8'h41 : 8'h20};
    for (int i = 0; i < 10; i++) begin
      got[i] = pop_nib();
      exp = {eb[i/2][8], (i % 2 == 1) ? eb[i/2][3:0] : eb[i/2][7:4]};
      chk($sformatf("%s_nib%0d", tag, i), 32'(got[i]), 32'(exp));
    end
    for (int k = 0; k < 5; k++) begin
      b = {got[2*k][3:0], got[2*k+1][3:0]};
      if (!got[2*k][4] && b[7]) addr = int'(b[6:0]);
      else if (got[2*k][4]) begin
        if (addr < 4) dd[addr] = b;
        addr++;
      end
    end
  endtask

  function automatic logic [31:0] disp_word();
    return {dd[0], dd[1], dd[2], dd[3]};
  endfunction

  task automatic clear_queues();
    nib_cap.delete(); ehigh_q.delete(); frame_len_q.delete(); low_len_q.delete();
  endtask

  initial begin
    logic [8:0] cur_v, v;
    int n, sum;
    for (int i = 0; i < 4; i++) dd[i] = 8'h20;
    bus.disp_data = 8'h00;
    bus.disp_alarm = 1'b0;

    // Scenario 1: reset values, power-up wait, init sequence timing
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    rel_cyc = cyc;
    wait_init(400);
    chk("init_done_time", 32'(init_cyc - rel_cyc), 220);
    chk("first_e_rise", 32'(first_rise), 51);

    // Scenario 2: forced frame after init
    wait_idle(300, "forced_idle");
    check_init();
    check_frame(8'h00, 1'b0, "forced");
    chk("forced_display", disp_word(), 32'h30302020);
    chk("forced_len", 32'(frame_len_q[0]), 100);

    // Scenario 3: hex letters and alarm marker
    clear_queues();
    @(negedge clk);
    bus.disp_data = 8'hA7; bus.disp_alarm = 1'b1;
    wait_idle(300, "a7_idle");
    check_frame(8'hA7, 1'b1, "a7_alarm");
    chk("a7_display", disp_word(), 32'h41372041);
    chk("a7_len", 32'(frame_len_q[0]), 100);
    @(negedge clk);
    bus.disp_alarm = 1'b0;
    wait_idle(300, "a7_noalarm_idle");
    check_frame(8'hA7, 1'b0, "a7_noalarm");
    chk("a7_noalarm_display", disp_word(), 32'h41372020);
    cur_v = 9'h0A7;

    // Random frames with random ena stalls
    for (int it = 0; it < 6; it++) begin
      v = 9'($urandom);
      while (v == cur_v || v == 9'h03C || v == 9'h0F1) v = 9'($urandom);
      @(negedge clk);
      bus.disp_alarm = v[8]; bus.disp_data = v[7:0];
      @(negedge clk);
      @(negedge clk);
      n = 0;
      while (bus.busy !== 1'b0 && n < 3000) begin
        @(negedge clk);
        ena = ($urandom_range(0, 7) != 0);
        n++;
      end
      ena = 1'b1;
      chk("rand_idle", 32'(bus.busy), 0);
      check_frame(v[7:0], v[8], $sformatf("rand%0d", it));
      chk($sformatf("rand%0d_display", it), disp_word(),
          {hexc(v[7:4]), hexc(v[3:0]), 8'h20, v[8] ? 8'h41 : 8'h20});
      cur_v = v;
    end

    // Scenario 4: input change during a frame is picked up afterwards
    @(negedge clk);
    clear_queues();
    bus.disp_alarm = 1'b0; bus.disp_data = 8'h3C;
    repeat (30) @(negedge clk);
    bus.disp_data = 8'hF1;
    wait_idle(300, "chg_idle1");
    wait_idle(300, "chg_idle2");
    check_frame(8'h3C, 1'b0, "chg_first");
    check_frame(8'hF1, 1'b0, "chg_second");
    chk("chg_display", disp_word(), 32'h46312020);
    chk("chg_low_count", 32'(low_len_q.size()), 2);
    chk("chg_busy_low_1cyc", 32'(low_len_q[1]), 1);
    chk("chg_len0", 32'(frame_len_q[0]), 100);
    chk("chg_len1", 32'(frame_len_q[1]), 100);

    // Scenario 5: ena stall during the first HIGH phase
    @(negedge clk);
    clear_queues();
    v = {1'b1, 8'($urandom)};
    bus.disp_alarm = v[8]; bus.disp_data = v[7:0];
    n = 0;
    @(negedge clk);
    while (bus.lcd_e !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("stall_e_high", 32'(bus.lcd_e), 1);
    ena = 1'b0;
    repeat (7) @(negedge clk);
    chk("stall_e_held", 32'(bus.lcd_e), 1);
    ena = 1'b1;
    wait_idle(300, "stall_idle");
    check_frame(v[7:0], 1'b1, "stall");
    chk("stall_len", 32'(frame_len_q[0]), 107);
    sum = 0;
    foreach (ehigh_q[i]) sum += ehigh_q[i];
    chk("stall_ehigh_count", 32'(ehigh_q.size()), 10);
    chk("stall_ehigh_sum", 32'(sum), 27);

    // Scenario 6: reset mid-frame restarts from power-up
    @(negedge clk);
    v = {1'b0, v[7:0] ^ 8'h5A};
    bus.disp_alarm = v[8]; bus.disp_data = v[7:0];
    repeat (40) @(negedge clk);
    chk("midframe_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    clear_queues();
    rst_n = 1'b1;
    rel_cyc = cyc;
    wait_init(400);
    chk("re_init_done_time", 32'(init_cyc - rel_cyc), 220);
    chk("re_first_e_rise", 32'(first_rise), 51);
    wait_idle(300, "re_forced_idle");
    check_init();
    check_frame(v[7:0], v[8], "re_forced");
    chk("re_forced_len", 32'(frame_len_q[0]), 100);
    chk("re_leftover", 32'(nib_cap.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/med_lcd_driver.md
Name: med_lcd_driver

Overview:
- Downstream display stage for the medication scheduler.
- Takes the scheduler's 8-bit display byte (selected log entry) and its medication-due flag.
- Drives an HD44780-compatible character LCD in 4-bit mode: power-up init sequence, then a 4-character line-1 frame "HH A" showing the byte as two uppercase hex digits plus an alarm marker.
- Frames are rewritten only when the inputs change.

Parameters:
- E_CYCLES, 5: clk cycles lcd_e is held high, and then held low, per nibble.
- CMD_WAIT, 500: clk cycles idle after each byte (and after each init nibble).
- CLEAR_WAIT, 20000: clk cycles idle after the 0x01 clear command, replacing CMD_WAIT.
- POWERUP_WAIT, 200000: clk cycles idle after reset before the first nibble.
- All parameters are ≥1 and <2^20. Delay counter is 20 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  clock enable; when low all state, counters and outputs hold
- disp_data  in  8  byte to display (scheduler LCD register)
- disp_alarm  in  1  medication-due flag
- lcd_db  out  4  LCD data nibble (DB7..DB4)
- lcd_rs  out  1  0 = command, 1 = data
- lcd_e  out  1  LCD enable strobe
- busy  out  1  high during init or frame write
- init_done  out  1  high once init completes; stays high until reset

Behaviour:
- Reset and clocking
  - Reset is asynchronous, active-low on rst_n; clock is clk.
  - Reset values: lcd_db=0, lcd_rs=0, lcd_e=0, busy=1, init_done=0, snapshot registers=0, state=PWRUP, counter=0.
  - Reset mid-operation aborts any transfer immediately and restarts from PWRUP.
  - All outputs are registered. Only enabled cycles (ena=1) count toward any delay.
- Nibble transfer, 1+2*E_CYCLES cycles:
  - SETUP, 1 cycle: lcd_db and lcd_rs driven, lcd_e=0.
  - HIGH, E_CYCLES cycles: lcd_e=1.
  - LOW, E_CYCLES cycles: lcd_e=0.
  - lcd_db and lcd_rs stay stable through all three phases.
- Byte transfer: high nibble, then low nibble, then WAIT of CMD_WAIT cycles (CLEAR_WAIT if the byte is 0x01).
- State machine: PWRUP -> INIT -> IDLE <-> FRAME.
  - PWRUP: wait POWERUP_WAIT cycles.
  - INIT, rs=0:
    - single nibbles 0x3, 0x3, 0x3, 0x2, each followed by CMD_WAIT;
    - then bytes 0x28, 0x0C, 0x01, 0x06.
    - On expiry of the final wait, init_done goes high and the FSM enters FRAME with a forced refresh.
  - IDLE:
    - busy=0, lcd_e=0.
    - If {disp_alarm, disp_data} differs from the snapshot, capture it into the snapshot and enter FRAME next cycle, busy=1.
  - FRAME: write 5 bytes from the snapshot:
    - 0x80 (rs=0, DDRAM address 0);
    - hex(snapshot[7:4]) (rs=1);
    - hex(snapshot[3:0]) (rs=1);
    - 0x20 (rs=1);
    - 0x41 'A' if the alarm snapshot=1, else 0x20 (rs=1).
    - After the last wait, return to IDLE.
- Hex encoding: n<10 -> 0x30+n; n≥10 -> 0x37+n (A–F uppercase).
- Input changes during a FRAME do not abort it. They are picked up by the IDLE comparison after the frame, so the last value always ends up displayed.
  - One change per IDLE entry; no queueing beyond the snapshot compare.
- The forced refresh after init writes the current inputs even if they equal the reset snapshot (0).
- ena low at any point freezes the FSM mid-phase with lcd_e held at its current level. Resuming continues exactly where it stopped.

Test Plan (parameters E_CYCLES=2, CMD_WAIT=10, CLEAR_WAIT=40, POWERUP_WAIT=50; nibble = 5 cycles, byte = 20 cycles, frame = 100 cycles):
1. Init: release reset with ena=1, disp_data=0x00 -> lcd_e stays 0 for 50 cycles; nibble sequence 3,3,3,2 then 2,8,0,C,0,1,0,6 with rs=0; init_done rises exactly 220 enabled cycles after reset release.
2. Forced frame: continue from 1 -> nibbles 8,0 (rs=0), then 3,0,3,0,2,0,2,0 (rs=1); busy falls 100 cycles after init_done rises. Decoded LCD shows "00  ".
3. Hex and alarm: in IDLE, set disp_data=0xA7, disp_alarm=1 -> data bytes 0x41, 0x37, 0x20, 0x41; shows "A7 A". Then disp_alarm=0 -> new frame ends in 0x20.
4. Change during frame: set 0x3C, then 30 cycles into that frame set 0xF1 -> 0x3C frame completes unaltered; busy low for exactly 1 cycle; second frame writes 0x46, 0x31.
5. ena stall: drop ena for 7 cycles during a HIGH phase -> lcd_e stays 1 for 7 extra cycles; total frame length 107 cycles; byte content unchanged.
6. Reset mid-frame: assert rst_n low during FRAME -> outputs 0, busy=1, init_done=0 immediately; after release the full scenario-1 sequence repeats.
